// File: rtl/serial_pkg.sv
// serial_pkg: shared receiver FSM state encoding and frame width
package serial_pkg;
  localparam int DATA_BITS = 8;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
endpackage

// File: rtl/serial_rx_if.sv
// serial_rx_if: serial line, bit strobe and byte-stream handshake of the receiver
// master drives sin/bit_en/ready and observes the received byte and status flags;
// slave is the receiver side.
interface serial_rx_if;
  import serial_pkg::*;
  logic                 sin;
  logic                 bit_en;
  logic                 ready;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  modport master (output sin, bit_en, ready, input data, valid, parity_err, frame_err, overrun);
  modport slave (input sin, bit_en, ready, output data, valid, parity_err, frame_err, overrun);
endinterface

// File: rtl/serial_rx.sv
// serial_rx: strobed UART-style receiver (start, 8 data MSB first, optional even parity, stop)
// clk/rst: clock and synchronous active-high reset; bus: serial_rx_if.slave carrying
// sin/bit_en/ready in and data/valid/parity_err/frame_err/overrun out.
module serial_rx
  import serial_pkg::*;
#(
  parameter bit PARITY_EN = 1'b1
) (
  input logic     clk,
  input logic     rst,
  serial_rx_if.slave bus
);
  rx_state_t            state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 pe_q, pe_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 hs;
  assign hs = valid_q && bus.ready;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    pe_d    = pe_q;
    data_d  = data_q;
    valid_d = valid_q && !bus.ready;
    perr_d  = perr_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;
    if (bus.bit_en) begin
      case (state_q)
        IDLE: begin
          // pe cleared at frame start so a parity-less frame reports no error
          state_d = bus.sin ? IDLE : DATA;
          cnt_d   = bus.sin ? cnt_q : 3'd0;
          pe_d    = bus.sin ? pe_q : 1'b0;
        end
        DATA: begin
          sh_d  = {sh_q[DATA_BITS-2:0], bus.sin};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'(DATA_BITS - 1)) state_d = PARITY_EN ? PARITY : STOP;
        end
        PARITY: begin
          pe_d    = (^sh_q) ^ bus.sin;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          // a good frame is delivered if the output slot is free or freed this very edge
          if (!bus.sin) ferr_d = 1'b1;
          else if (!valid_q || hs) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            perr_d  = pe_q;
          end else ovr_d = 1'b1;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      pe_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      pe_q    <= pe_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
  assign bus.data       = data_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: directed frames with a scoreboard of expected {parity_err, data} per accepted byte
module tb_serial_rx;
  localparam bit PEN = 1'b1;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  int   ferr_n = 0;
  logic [8:0] exp_q[$];
  serial_rx_if bus();
  serial_rx #(.PARITY_EN(PEN)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic tx_bit(input logic v, input bit r_on);
    bus.sin    = v;
    bus.bit_en = 1'b0;
    cyc(2);
    bus.bit_en = 1'b1;
    if (r_on) bus.ready = 1'b1;
    cyc(1);
    bus.bit_en = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input bit pflip, input logic stopv, input bit rdy_stop);
    tx_bit(1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) tx_bit(b[i], 1'b0);
    if (PEN) tx_bit((^b) ^ pflip, 1'b0);
    tx_bit(stopv, rdy_stop);
    bus.sin = 1'b1;
  endtask
  // inputs change 1ns after posedge, so at negedge valid&&ready means the byte is taken next edge
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) ferr_n++;
    if (bus.valid === 1'b1 && bus.ready === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_byte", {23'd0, bus.parity_err, bus.data}, 32'h1ff);
      else chk("sb_byte", {23'd0, bus.parity_err, bus.data}, {23'd0, exp_q.pop_front()});
    end
  end
  initial begin
    rst = 1'b1;
    bus.sin = 1'b1;
    bus.bit_en = 1'b0;
    bus.ready = 1'b1;
    cyc(2);
    chk("rst_valid", bus.valid, 0);
    chk("rst_data", bus.data, 0);
    chk("rst_flags", {bus.parity_err, bus.frame_err, bus.overrun}, 0);
    rst = 1'b0;
    cyc(2);
    exp_q.push_back({1'b0, 8'hA5});
    send(8'hA5, 1'b0, 1'b1, 1'b0);
    chk("a5_latency_valid", bus.valid, 1);
    chk("a5_data", bus.data, 8'hA5);
    chk("a5_ferr", bus.frame_err, 0);
    cyc(1);
    chk("a5_valid_one_cycle", bus.valid, 0);
    exp_q.push_back({1'b1, 8'hA5});
    send(8'hA5, 1'b1, 1'b1, 1'b0);
    chk("a5_perr", {bus.valid, bus.parity_err}, 2'b11);
    cyc(2);
    send(8'h5A, 1'b0, 1'b0, 1'b0);
    chk("5a_ferr_pulse", bus.frame_err, 1);
    chk("5a_no_valid", bus.valid, 0);
    cyc(1);
    chk("5a_ferr_clear", bus.frame_err, 0);
    chk("5a_ferr_count", ferr_n, 1);
    exp_q.push_back({1'b0, 8'h11});
    send(8'h11, 1'b0, 1'b1, 1'b0);
    chk("11_data", {bus.valid, bus.data}, 9'h111);
    cyc(2);
    bus.ready = 1'b0;
    exp_q.push_back({1'b0, 8'h3C});
    send(8'h3C, 1'b0, 1'b1, 1'b0);
    chk("3c_no_ovr", bus.overrun, 0);
    send(8'h81, 1'b0, 1'b1, 1'b0);
    chk("ovr_held_data", {bus.valid, bus.data}, 9'h13C);
    chk("ovr_set", bus.overrun, 1);
    bus.ready = 1'b1;
    cyc(1);
    chk("ovr_valid_clear", bus.valid, 0);
    chk("ovr_sticky", bus.overrun, 1);
    rst = 1'b1;
    bus.ready = 1'b0;
    cyc(1);
    rst = 1'b0;
    chk("rst_ovr_clear", bus.overrun, 0);
    exp_q.push_back({1'b0, 8'h3C});
    send(8'h3C, 1'b0, 1'b1, 1'b0);
    exp_q.push_back({1'b0, 8'h81});
    send(8'h81, 1'b0, 1'b1, 1'b1);
    chk("coinc_data", {bus.valid, bus.data}, 9'h181);
    chk("coinc_no_ovr", bus.overrun, 0);
    cyc(2);
    tx_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tx_bit(1'b1, 1'b0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("midrst_out", {bus.valid, bus.data, bus.parity_err, bus.frame_err, bus.overrun}, 0);
    bus.sin = 1'b1;
    exp_q.push_back({1'b0, 8'h0F});
    send(8'h0F, 1'b0, 1'b1, 1'b0);
    chk("0f_data", {bus.valid, bus.data}, 9'h10F);
    chk("0f_flags", {bus.parity_err, bus.frame_err, bus.overrun}, 0);
    cyc(3);
    chk("sb_drained", exp_q.size(), 0);
    chk("ferr_total", ferr_n, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
